// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: multi-digit seven-segment scan controller.
//
// Time-multiplexes NUM_DIGITS hex digits onto one shared segment bus.
// Inputs are captured into shadow registers once per frame, so a change on
// hex_in never tears a frame.
//
// Features:
//   - leading-zero blanking
//   - per-digit blink
//   - 16-level PWM brightness
//   - selectable anode and segment polarity
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   hex_in     digit values, digit i = hex_in[4i+3:4i], digit 0 rightmost
//   dp_in      decimal point per digit (1 = lit)
//   blank_lz   leading-zero blanking enable (sampled at frame capture)
//   blink_en   per-digit blink enable (sampled at frame capture)
//   bright     brightness 0..15, used live
//   disp_en    0 forces every digit dark, used live
//   an         digit enables, one-hot when lit
//   sseg       segments {dp, a, b, c, d, e, f, g}
//   frame_tick one-cycle pulse on the first cycle of digit 0
module disp_scan_ctrl #(
  parameter int NUM_DIGITS     = 8,
  parameter int PRESCALE_W     = 16,
  parameter int BLINK_W        = 24,
  parameter bit AN_ACTIVE_LOW  = 1'b0,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] hex_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  input  logic [3:0]              bright,
  input  logic                    disp_en,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              sseg,
  output logic                    frame_tick
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{AN_ACTIVE_LOW}};
  localparam logic [7:0]            SEG_OFF  = {8{SEG_ACTIVE_LOW}};

  logic [PRESCALE_W-1:0]      pre_q, pre_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [BLINK_W-1:0]         blink_cnt_q, blink_cnt_d;
  logic                       blink_phase_q, blink_phase_d;
  logic [NUM_DIGITS-1:0][3:0] hex_sh_q, hex_sh_d;
  logic [NUM_DIGITS-1:0]      dp_sh_q, dp_sh_d;
  logic                       blz_sh_q, blz_sh_d;
  logic [NUM_DIGITS-1:0]      blink_sh_q, blink_sh_d;
  logic [NUM_DIGITS-1:0]      an_q, an_d;
  logic [7:0]                 sseg_q, sseg_d;
  logic                       frame_tick_q, frame_tick_d;

  logic                  slot_end, frame_end;
  logic [NUM_DIGITS-1:0] lz_blank;
  logic                  zero_run;
  logic [3:0]            cur_hex;
  logic [6:0]            seg_abcdefg;
  logic                  pwm_on, dark;

  always_comb begin
    slot_end  = &pre_q;
    frame_end = slot_end && (idx_q == LAST_IDX);

    pre_d = pre_q + PRESCALE_W'(1);
    idx_d = idx_q;
    if (slot_end) idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);

    blink_cnt_d   = blink_cnt_q + BLINK_W'(1);
    blink_phase_d = (&blink_cnt_q) ? ~blink_phase_q : blink_phase_q;

    hex_sh_d   = hex_sh_q;
    dp_sh_d    = dp_sh_q;
    blz_sh_d   = blz_sh_q;
    blink_sh_d = blink_sh_q;
    if (frame_end) begin
      hex_sh_d   = hex_in;
      dp_sh_d    = dp_in;
      blz_sh_d   = blank_lz;
      blink_sh_d = blink_en;
    end
    frame_tick_d = frame_end;

    // Walk from the most significant digit down; a digit is a leading zero
    // while it and everything above it is zero with no decimal point.
    lz_blank = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (hex_sh_q[i] == 4'h0) && !dp_sh_q[i];
      lz_blank[i] = blz_sh_q && zero_run && (i != 0);
    end

    cur_hex = hex_sh_q[idx_q];
    unique case (cur_hex)
      4'h0: seg_abcdefg = 7'h7E;
      4'h1: seg_abcdefg = 7'h30;
      4'h2: seg_abcdefg = 7'h6D;
      4'h3: seg_abcdefg = 7'h79;
      4'h4: seg_abcdefg = 7'h33;
      4'h5: seg_abcdefg = 7'h5B;
      4'h6: seg_abcdefg = 7'h5F;
      4'h7: seg_abcdefg = 7'h70;
      4'h8: seg_abcdefg = 7'h7F;
      4'h9: seg_abcdefg = 7'h7B;
      4'hA: seg_abcdefg = 7'h77;
      4'hB: seg_abcdefg = 7'h1F;
      4'hC: seg_abcdefg = 7'h4E;
      4'hD: seg_abcdefg = 7'h3D;
      4'hE: seg_abcdefg = 7'h4F;
      default: seg_abcdefg = 7'h47;
    endcase

    // Top four prescaler bits form a 16-step PWM ramp within each slot.
    pwm_on = (pre_q[PRESCALE_W-1 -: 4] <= bright);
    dark   = lz_blank[idx_q] || (blink_phase_q && blink_sh_q[idx_q]) ||
             !pwm_on || !disp_en;

    an_d   = (dark ? '0 : (NUM_DIGITS'(1) << idx_q)) ^ AN_OFF;
    sseg_d = (dark ? 8'h00 : {dp_sh_q[idx_q], seg_abcdefg}) ^ SEG_OFF;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q         <= '0;
      idx_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      hex_sh_q      <= '0;
      dp_sh_q       <= '0;
      blz_sh_q      <= 1'b0;
      blink_sh_q    <= '0;
      an_q          <= AN_OFF;
      sseg_q        <= SEG_OFF;
      frame_tick_q  <= 1'b0;
    end else begin
      pre_q         <= pre_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      hex_sh_q      <= hex_sh_d;
      dp_sh_q       <= dp_sh_d;
      blz_sh_q      <= blz_sh_d;
      blink_sh_q    <= blink_sh_d;
      an_q          <= an_d;
      sseg_q        <= sseg_d;
      frame_tick_q  <= frame_tick_d;
    end
  end

  assign an         = an_q;
  assign sseg       = sseg_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
module tb_disp_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] hex_in = 16'h1234;
  logic [3:0]  dp_in = 4'b0000;
  logic        blank_lz = 1'b0;
  logic [3:0]  blink_en = 4'b0000;
  logic [3:0]  bright = 4'd15;
  logic        disp_en = 1'b1;
  logic [3:0]  an;
  logic [7:0]  sseg;
  logic        frame_tick;

  int n_checks = 0;
  int n_pass   = 0;

  // Inverted segment patterns (SEG_ACTIVE_LOW) indexed by digit position.
  localparam logic [7:0] SEG_1234 [4] = '{8'hCC, 8'h86, 8'h92, 8'hCF};
  localparam logic [7:0] SEG_ABCD [4] = '{8'hC2, 8'hB1, 8'hE0, 8'h88};
  localparam logic [7:0] SEG_ZERO    = 8'h81;
  localparam logic [7:0] SEG_FIVE    = 8'hA4;
  localparam logic [7:0] SEG_ZERO_DP = 8'h01;

  disp_scan_ctrl #(
    .NUM_DIGITS(4), .PRESCALE_W(4), .BLINK_W(6),
    .AN_ACTIVE_LOW(1'b0), .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .hex_in(hex_in), .dp_in(dp_in),
    .blank_lz(blank_lz), .blink_en(blink_en), .bright(bright),
    .disp_en(disp_en), .an(an), .sseg(sseg), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    hex_in = 16'h1234; dp_in = 4'b0; blank_lz = 1'b0; blink_en = 4'b0;
    bright = 4'd15; disp_en = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (an !== 4'b0000) $display("FAIL reset_an got %b exp 0000", an); else n_pass++;
    n_checks++;
    if (sseg !== 8'hFF) $display("FAIL reset_sseg got %h exp ff", sseg); else n_pass++;
    n_checks++;
    if (frame_tick !== 1'b0) $display("FAIL reset_ft got %b exp 0", frame_tick); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Continues directly from test_reset's release.
  task automatic test_scan();
    logic [3:0] exp_an;
    logic [7:0] exp_seg;
    for (int n = 1; n <= 128; n++) begin
      step();
      exp_an  = 4'b0001 << (((n - 1) / 16) % 4);
      exp_seg = (n <= 64) ? SEG_ZERO : SEG_1234[((n - 1) / 16) % 4];
      n_checks++;
      if (frame_tick !== (n == 64 || n == 128))
        $display("FAIL scan_ft n=%0d got %b", n, frame_tick);
      else n_pass++;
      n_checks++;
      if (an !== exp_an) $display("FAIL scan_an n=%0d got %b exp %b", n, an, exp_an);
      else n_pass++;
      n_checks++;
      if (sseg !== exp_seg) $display("FAIL scan_sseg n=%0d got %h exp %h", n, sseg, exp_seg);
      else n_pass++;
    end
  endtask

  task automatic test_blank();
    int d, f;
    logic [3:0] exp_an;
    logic [7:0] exp_seg;
    hex_in = 16'h0050; dp_in = 4'b0000; blank_lz = 1'b1; bright = 4'd15;
    apply_reset();
    for (int n = 1; n <= 192; n++) begin
      step();
      d = ((n - 1) / 16) % 4;
      f = (n - 1) / 64;
      exp_an = 4'b0001 << d;
      if (f == 0) exp_seg = SEG_ZERO;
      else if (d == 0) exp_seg = SEG_ZERO;
      else if (d == 1) exp_seg = SEG_FIVE;
      else if (d == 2 && f == 2) exp_seg = SEG_ZERO_DP;
      else begin
        exp_seg = 8'hFF;
        exp_an  = 4'b0000;
      end
      n_checks++;
      if (an !== exp_an) $display("FAIL blank_an n=%0d got %b exp %b", n, an, exp_an);
      else n_pass++;
      n_checks++;
      if (sseg !== exp_seg) $display("FAIL blank_sseg n=%0d got %h exp %h", n, sseg, exp_seg);
      else n_pass++;
      if (n == 70) dp_in = 4'b0100;
    end
    blank_lz = 1'b0; dp_in = 4'b0000;
  endtask

  task automatic test_pwm();
    int k, cnt;
    logic exp_lit;
    hex_in = 16'h1234; bright = 4'd3;
    apply_reset();
    repeat (64) step();
    cnt = 0;
    for (int n = 65; n <= 192; n++) begin
      step();
      k = (n - 1) % 16;
      exp_lit = (n <= 128) ? (k <= 3) : (k == 0);
      if (an != 4'b0000) cnt++;
      n_checks++;
      if ((an != 4'b0000) !== exp_lit)
        $display("FAIL pwm_lit n=%0d got an=%b exp lit=%b", n, an, exp_lit);
      else n_pass++;
      if (k == 15) begin
        n_checks++;
        if (cnt !== ((n <= 128) ? 4 : 1))
          $display("FAIL pwm_count n=%0d got %0d exp %0d", n, cnt, (n <= 128) ? 4 : 1);
        else n_pass++;
        cnt = 0;
      end
      if (n == 128) bright = 4'd0;
    end
    bright = 4'd15;
  endtask

  task automatic test_disp_en();
    hex_in = 16'h1234; bright = 4'd15; disp_en = 1'b1;
    apply_reset();
    repeat (70) step();
    n_checks++;
    if (an !== 4'b0001) $display("FAIL den_before got %b exp 0001", an); else n_pass++;
    disp_en = 1'b0;
    step();
    n_checks++;
    if (an !== 4'b0000 || sseg !== 8'hFF)
      $display("FAIL den_dark got an=%b sseg=%h exp 0000/ff", an, sseg);
    else n_pass++;
    repeat (57) step();
    n_checks++;
    if (frame_tick !== 1'b1) $display("FAIL den_ft got %b exp 1", frame_tick); else n_pass++;
    disp_en = 1'b1;
    step();
    n_checks++;
    if (an !== 4'b0001 || sseg !== SEG_1234[0])
      $display("FAIL den_resume got an=%b sseg=%h exp 0001/%h", an, sseg, SEG_1234[0]);
    else n_pass++;
  endtask

  task automatic test_blink();
    int d, f;
    logic exp_dark;
    hex_in = 16'h1234; blink_en = 4'b0001; bright = 4'd15;
    apply_reset();
    for (int n = 1; n <= 256; n++) begin
      step();
      d = ((n - 1) / 16) % 4;
      f = (n - 1) / 64;
      exp_dark = (d == 0) && (f % 2 == 1);
      n_checks++;
      if (exp_dark) begin
        if (an !== 4'b0000 || sseg !== 8'hFF)
          $display("FAIL blink_dark n=%0d got an=%b sseg=%h exp 0000/ff", n, an, sseg);
        else n_pass++;
      end else begin
        if (an !== (4'b0001 << d))
          $display("FAIL blink_lit n=%0d got an=%b exp digit %0d", n, an, d);
        else n_pass++;
      end
    end
    blink_en = 4'b0000;
  endtask

  task automatic test_back_to_back();
    int d;
    logic [7:0] exp_seg;
    hex_in = 16'h1234; bright = 4'd15;
    apply_reset();
    for (int n = 1; n <= 192; n++) begin
      step();
      d = ((n - 1) / 16) % 4;
      if (n <= 64) exp_seg = SEG_ZERO;
      else if (n <= 128) exp_seg = SEG_1234[d];
      else exp_seg = SEG_ABCD[d];
      n_checks++;
      if (sseg !== exp_seg) $display("FAIL coherent_sseg n=%0d got %h exp %h", n, sseg, exp_seg);
      else n_pass++;
      if (n == 85) hex_in = 16'hABCD;
      if (n == 150) hex_in = 16'h0000;
    end
  endtask

  task automatic test_reset_mid();
    int got;
    hex_in = 16'h1234; bright = 4'd15;
    apply_reset();
    repeat (100) step();
    n_checks++;
    if (an !== 4'b0100) $display("FAIL rmid_pre got %b exp 0100", an); else n_pass++;
    #1;
    reset = 1'b1;
    #1;
    n_checks++;
    if (an !== 4'b0000 || sseg !== 8'hFF || frame_tick !== 1'b0)
      $display("FAIL rmid_async got an=%b sseg=%h ft=%b exp 0000/ff/0", an, sseg, frame_tick);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    step();
    n_checks++;
    if (an !== 4'b0001 || sseg !== SEG_ZERO)
      $display("FAIL rmid_first got an=%b sseg=%h exp 0001/%h", an, sseg, SEG_ZERO);
    else n_pass++;
    got = -1;
    for (int n = 2; n <= 200; n++) begin
      step();
      if (frame_tick === 1'b1) begin
        got = n;
        break;
      end
    end
    n_checks++;
    if (got !== 64) $display("FAIL rmid_ft_delay got %0d exp 64", got); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_blank();
    test_pwm();
    test_disp_en();
    test_blink();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
